encoder_pwm_capture: RTL and testbench



---
 rtl/enc_capture_pkg.sv | 29 ++
 rtl/seq_divider.sv | 82 ++++++++
 rtl/encoder_pwm_capture.sv | 196 +++++++++++++++++++
 tb/tb_encoder_pwm_capture.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/enc_capture_pkg.sv
// Shared constants, FSM state type and angle clamp helper for the encoder PWM capture path.
package enc_capture_pkg;

  localparam int unsigned FRAME_UNITS = 4351;
  localparam int unsigned HEAD_UNITS  = 128;
  localparam int unsigned ANGLE_MAX   = 4095;
  localparam int unsigned ANGLE_W     = 12;
  localparam int unsigned Q_W         = 13;
  localparam int unsigned GLITCH_LEN  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DIV  = 3'd4,
    ST_OUT  = 3'd5
  } state_e;

  // Strip the frame header and saturate into the 12-bit angle range.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [Q_W-1:0] q);
    logic [Q_W-1:0] diff;
    diff = q - Q_W'(HEAD_UNITS);
    if (q < Q_W'(HEAD_UNITS)) return '0;
    if (diff > Q_W'(ANGLE_MAX)) return ANGLE_W'(ANGLE_MAX);
    return ANGLE_W'(diff);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start cycle.
module seq_divider #(
  parameter int unsigned DVS_W = 16,
  parameter int unsigned Q_W   = 13
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DVS_W+Q_W-1:0]   dividend,
  input  logic [DVS_W-1:0]       divisor,
  output logic                   busy,
  output logic                   done,
  output logic [Q_W-1:0]         quotient
);

  localparam int unsigned ACC_W = DVS_W + Q_W;
  localparam int unsigned ITR_W = $clog2(Q_W);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [ITR_W-1:0] itr_q, itr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Upper DVS_W bits hold the partial remainder, lower bits shift dividend out and quotient in.
  function automatic logic [ACC_W-1:0] div_step(input logic [ACC_W-1:0] acc,
                                                input logic [DVS_W-1:0] dvs);
    logic [DVS_W:0]   trial;
    logic [DVS_W-1:0] rem;
    logic             qbit;
    trial = acc[ACC_W-1:Q_W-1];
    qbit  = (trial >= {1'b0, dvs});
    rem   = qbit ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
    return {rem, acc[Q_W-2:0], qbit};
  endfunction

  always_comb begin
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    itr_d  = itr_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort) begin
      busy_d = 1'b0;
      itr_d  = '0;
    end else if (start) begin
      acc_d  = div_step(dividend, divisor);
      dvs_d  = divisor;
      itr_d  = ITR_W'(Q_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      acc_d = div_step(acc_q, dvs_q);
      itr_d = itr_q - 1'b1;
      if (itr_q == ITR_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      itr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      itr_q  <= itr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = acc_q[Q_W-1:0];

endmodule

// File: rtl/encoder_pwm_capture.sv
// Decodes the magnetic encoder PWM frame into a 12-bit angle with valid/timeout/error flags.
// Define ENC_DEGLITCH_EN to filter the synchronised input before edge detection.
module encoder_pwm_capture
  import enc_capture_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_PERIOD = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               enc_pwm,
  output logic [ANGLE_W-1:0] current_angle,
  output logic               angle_valid,
  output logic               enc_timeout,
  output logic               enc_error
);

  localparam int unsigned DVD_W = CNT_W + Q_W;

  state_e             state_q, state_d;
  logic [1:0]         sync_q, sync_d;
  logic               prev_q;
  logic               level;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               error_q, error_d;
  logic               rise, fall;
  logic               div_start, div_abort, div_busy, div_done;
  logic [DVD_W-1:0]   dividend;
  logic [Q_W-1:0]     quotient;

  assign sync_d = {sync_q[0], enc_pwm};

`ifdef ENC_DEGLITCH_EN
  localparam int unsigned GL_W = $clog2(GLITCH_LEN + 1);

  logic            filt_q, filt_d;
  logic [GL_W-1:0] gl_cnt_q, gl_cnt_d;

  // Level follows the input only after GLITCH_LEN consecutive differing samples.
  always_comb begin
    filt_d   = filt_q;
    gl_cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (gl_cnt_q == GL_W'(GLITCH_LEN - 1)) filt_d = sync_q[1];
      else                                   gl_cnt_d = gl_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q   <= 1'b0;
      gl_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      gl_cnt_q <= gl_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  assign rise     = level & ~prev_q;
  assign fall     = ~level & prev_q;
  assign dividend = DVD_W'(hi_cnt_q) * DVD_W'(FRAME_UNITS);

  seq_divider #(
    .DVS_W (CNT_W),
    .Q_W   (Q_W)
  ) u_div (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (dividend),
    .divisor  (per_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    angle_d   = angle_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    error_d   = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (!enable) begin
      state_d   = ST_IDLE;
      timeout_d = 1'b0;
      div_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_ARM;
          hi_cnt_d  = '0;
          per_cnt_d = '0;
        end
        ST_ARM: begin
          if (rise) begin
            hi_cnt_d  = CNT_W'(1);
            per_cnt_d = CNT_W'(1);
            state_d   = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (per_cnt_q == '1) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
          end else begin
            per_cnt_d = per_cnt_q + 1'b1;
            if (fall) state_d  = ST_LOW;
            else      hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end
        ST_LOW: begin
          // The rise that closes a frame also opens the next one.
          if (rise) begin
            hi_cnt_d  = CNT_W'(1);
            per_cnt_d = CNT_W'(1);
            if (per_cnt_q < CNT_W'(MIN_PERIOD)) begin
              error_d = 1'b1;
              state_d = ST_HIGH;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end else if (per_cnt_q == '1) begin
            timeout_d = 1'b1;
            state_d   = ST_ARM;
          end else begin
            per_cnt_d = per_cnt_q + 1'b1;
          end
        end
        ST_DIV: begin
          per_cnt_d = per_cnt_q + 1'b1;
          if (level) hi_cnt_d = hi_cnt_q + 1'b1;
          if (div_done) begin
            angle_d   = clamp_angle(quotient);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            state_d   = ST_OUT;
          end else if (!div_busy) begin
            state_d = ST_ARM;
          end
        end
        ST_OUT: begin
          per_cnt_d = per_cnt_q + 1'b1;
          if (level) hi_cnt_d = hi_cnt_q + 1'b1;
          state_d = level ? ST_HIGH : ST_LOW;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
      angle_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      prev_q    <= level;
      hi_cnt_q  <= hi_cnt_d;
      per_cnt_q <= per_cnt_d;
      angle_q   <= angle_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      error_q   <= error_d;
    end
  end

  assign current_angle = angle_q;
  assign angle_valid   = valid_q;
  assign enc_timeout   = timeout_q;
  assign enc_error     = error_q;

endmodule

// File: tb/tb_encoder_pwm_capture.sv
// Scoreboard bench for encoder_pwm_capture: frames are driven, expected angles queued, outputs popped.
module tb_encoder_pwm_capture;
  import enc_capture_pkg::*;

`ifdef ENC_DEGLITCH_EN
  localparam int LAT = 16 + int'(GLITCH_LEN);
`else
  localparam int LAT = 16;
`endif

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               enc_pwm;
  logic [ANGLE_W-1:0] current_angle;
  logic               angle_valid;
  logic               enc_timeout;
  logic               enc_error;

  typedef struct {
    int angle;
    int t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   err_seen = 0;
  int   err_exp  = 0;
  bit   pend_on  = 1'b0;
  int   pend_hi  = 0;
  int   pend_per = 0;
  int   t_rise   = 0;

  encoder_pwm_capture dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .enc_pwm       (enc_pwm),
    .current_angle (current_angle),
    .angle_valid   (angle_valid),
    .enc_timeout   (enc_timeout),
    .enc_error     (enc_error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_angle(input int hi, input int per);
    longint q;
    q = (longint'(hi) * longint'(FRAME_UNITS)) / longint'(per);
    if (q < longint'(HEAD_UNITS)) return 0;
    q = q - longint'(HEAD_UNITS);
    if (q > longint'(ANGLE_MAX)) return int'(ANGLE_MAX);
    return int'(q);
  endfunction

  // The rise that begins a frame closes the pending one, so its expectation is queued here.
  task automatic close_pending();
    if (pend_on) begin
      if (pend_per >= 64) sb.push_back('{angle: exp_angle(pend_hi, pend_per), t: cyc});
      else                err_exp++;
    end
    pend_on = 1'b0;
  endtask

  task automatic frame(input int hi, input int per, input int glitch);
    close_pending();
    pend_on  = 1'b1;
    pend_hi  = hi;
    pend_per = per;
    for (int i = 0; i < per; i++) begin
      enc_pwm = (i < hi) && !(glitch != 0 && i >= glitch && i < glitch + 2);
      @(negedge clock);
    end
  endtask

  always @(negedge clock) begin
    if (angle_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("angle", int'(current_angle), mon_e.angle);
        check_eq("latency", cyc - mon_e.t, LAT);
      end
    end
    if (enc_error) err_seen++;
  end

  initial begin
    int k;
    reset_n = 1'b0;
    enable  = 1'b0;
    enc_pwm = 1'b0;
    repeat (5) @(negedge clock);
    check_eq("rst_angle", int'(current_angle), 0);
    check_eq("rst_valid", int'(angle_valid), 0);
    check_eq("rst_timeout", int'(enc_timeout), 0);
    check_eq("rst_error", int'(enc_error), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Enable mid-high so the first partial frame must be discarded.
    enc_pwm = 1'b1;
    repeat (10) @(negedge clock);
    enable = 1'b1;
    repeat (200) @(negedge clock);
    enc_pwm = 1'b0;
    repeat (300) @(negedge clock);

    frame(1128, 4351, 0);
    frame(2256, 8702, 0);
    frame(100, 4351, 0);
    frame(4300, 4351, 0);
`ifdef ENC_DEGLITCH_EN
    frame(1128, 4351, 500);
`endif
    frame(20, 40, 0);
    frame(20, 40, 0);
    frame(300, 600, 0);
    check_eq("error_count", err_seen, err_exp);

    // Reset during DIV cycle 6 of the 300/600 frame.
    pend_on = 1'b0;
    enc_pwm = 1'b1;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_angle", int'(current_angle), 0);
    check_eq("midrst_valid", int'(angle_valid), 0);
    check_eq("midrst_timeout", int'(enc_timeout), 0);
    check_eq("midrst_error", int'(enc_error), 0);
    @(negedge clock);
    enc_pwm = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    frame(300, 600, 0);
    frame(300, 600, 0);

    // Close the last frame, then hold low until the period counter saturates.
    close_pending();
    t_rise  = cyc;
    enc_pwm = 1'b1;
    repeat (300) @(negedge clock);
    enc_pwm = 1'b0;
    k = 0;
    while (!enc_timeout && k < 70000) begin
      @(negedge clock);
      k++;
    end
    check_eq("timeout_set", int'(enc_timeout), 1);
    check_eq("timeout_window", int'((cyc - t_rise) >= 65534 && (cyc - t_rise) <= 65542), 1);
    check_eq("timeout_hold_angle", int'(current_angle), exp_angle(300, 600));
    repeat (50) @(negedge clock);
    check_eq("timeout_sticky", int'(enc_timeout), 1);

    frame(300, 600, 0);
    check_eq("timeout_before_valid", int'(enc_timeout), 1);
    frame(150, 600, 0);
    check_eq("timeout_cleared", int'(enc_timeout), 0);
    check_eq("resume_angle", int'(current_angle), exp_angle(300, 600));

    // Drop enable in the middle of a divide: no strobe, angle retained.
    pend_on = 1'b0;
    enc_pwm = 1'b1;
    repeat (6) @(negedge clock);
    enable = 1'b0;
    repeat (30) @(negedge clock);
    check_eq("disable_angle", int'(current_angle), exp_angle(300, 600));
    check_eq("disable_timeout", int'(enc_timeout), 0);

    repeat (40) @(negedge clock);
    check_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
